// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one 4-bit magnitude comparator across four
// requesters; grants one client, latches its operands, returns e/g/l.
module cmp_share_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] a_bus,
    input  logic [15:0] b_bus,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        res_e,
    output logic        res_g,
    output logic        res_l,
    output logic [1:0]  res_id,
    output logic [7:0]  cmp_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  id_q, id_d;
    logic [3:0]  op_a_q, op_a_d;
    logic [3:0]  op_b_q, op_b_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        done_q, done_d;
    logic        res_e_q, res_e_d;
    logic        res_g_q, res_g_d;
    logic        res_l_q, res_l_d;
    logic [1:0]  res_id_q, res_id_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the first asserted request wins.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        gnt_d    = 4'b0000;
        done_d   = 1'b0;
        res_e_d  = res_e_q;
        res_g_d  = res_g_q;
        res_l_d  = res_l_q;
        res_id_d = res_id_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = 4'b0001 << win;
                    op_a_d  = a_bus[{win, 2'b00} +: 4];
                    op_b_d  = b_bus[{win, 2'b00} +: 4];
                    id_d    = win;
                    ptr_d   = win + 2'd1;
                    state_d = CMP;
                end
            end
            CMP: begin
                res_e_d  = (op_a_q == op_b_q);
                res_g_d  = (op_a_q >  op_b_q);
                res_l_d  = (op_a_q <  op_b_q);
                res_id_d = id_q;
                done_d   = 1'b1;
                cnt_d    = cnt_q + 8'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            id_q     <= 2'd0;
            op_a_q   <= 4'd0;
            op_b_q   <= 4'd0;
            gnt_q    <= 4'd0;
            done_q   <= 1'b0;
            res_e_q  <= 1'b0;
            res_g_q  <= 1'b0;
            res_l_q  <= 1'b0;
            res_id_q <= 2'd0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            res_e_q  <= res_e_d;
            res_g_q  <= res_g_d;
            res_l_q  <= res_l_d;
            res_id_q <= res_id_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == CMP);
    assign done    = done_q;
    assign res_e   = res_e_q;
    assign res_g   = res_g_q;
    assign res_l   = res_l_q;
    assign res_id  = res_id_q;
    assign cmp_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed self-checking bench for cmp_share_arbiter.
module tb_cmp_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a_bus;
    logic [15:0] b_bus;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic        res_e;
    logic        res_g;
    logic        res_l;
    logic [1:0]  res_id;
    logic [7:0]  cmp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cmp_share_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_bus   (a_bus),
        .b_bus   (b_bus),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .res_e   (res_e),
        .res_g   (res_g),
        .res_l   (res_l),
        .res_id  (res_id),
        .cmp_cnt (cmp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read and inputs driven 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_bus = 16'h0;
        b_bus = 16'h0;
        do_reset();
        n_checks++;
        if ({gnt, busy, done, res_e, res_g, res_l, res_id, cmp_cnt} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got gnt=%b busy=%b done=%b e/g/l=%b%b%b id=%0d cnt=%0d want all 0",
                     gnt, busy, done, res_e, res_g, res_l, res_id, cmp_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        a_bus[3:0] = 4'h9;
        b_bus[3:0] = 4'h3;
        req = 4'b0001;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: got gnt=%b busy=%b done=%b want 0001 1 0", gnt, busy, done);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (done !== 1'b1 || gnt !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got done=%b gnt=%b busy=%b want 1 0000 0", done, gnt, busy);
        end
        n_checks++;
        if ({res_e, res_g, res_l} !== 3'b010 || res_id !== 2'd0 || cmp_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL single_result: got egl=%b%b%b id=%0d cnt=%0d want 010 0 1",
                     res_e, res_g, res_l, res_id, cmp_cnt);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || res_g !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold: got done=%b res_g=%b want 0 1", done, res_g);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [5];
        logic [2:0] exp_egl [4];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_egl = '{3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        a_bus = {4'hF, 4'h8, 4'h2, 4'h5};
        b_bus = {4'hF, 4'h1, 4'h7, 4'h5};
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (gnt !== exp_gnt[i] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got gnt=%b done=%b want %b 0", i, gnt, done, exp_gnt[i]);
            end
            step();
            n_checks++;
            if (done !== 1'b1 || gnt !== 4'b0000 ||
                {res_e, res_g, res_l} !== exp_egl[i] || res_id !== i[1:0]) begin
                n_fail++;
                $display("FAIL rr_result%0d: got done=%b gnt=%b egl=%b%b%b id=%0d want 1 0000 %b %0d",
                         i, done, gnt, res_e, res_g, res_l, res_id, exp_egl[i], i);
            end
        end
        step();
        n_checks++;
        if (gnt !== exp_gnt[4]) begin
            n_fail++;
            $display("FAIL rr_wrap: got gnt=%b want %b", gnt, exp_gnt[4]);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (cmp_cnt !== 8'd5 || res_id !== 2'd0 || res_l !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_count: got cnt=%0d id=%0d want 5 0", cmp_cnt, res_id);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        a_bus = 16'h0000;
        b_bus = 16'h0000;
        req   = 4'b0100;
        step();
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL fair_first: got gnt=%b want 0100", gnt);
        end
        req = 4'b0101;
        step();
        step();
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL fair_zero: got gnt=%b want 0001", gnt);
        end
        step();
        n_checks++;
        if (done !== 1'b1 || res_id !== 2'd0) begin
            n_fail++;
            $display("FAIL fair_done0: got done=%b id=%0d want 1 0", done, res_id);
        end
        step();
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++;
            $display("FAIL fair_two: got gnt=%b want 0100", gnt);
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        a_bus = 16'h0000;
        b_bus = 16'h0000;
        a_bus[3:0] = 4'h7;
        b_bus[3:0] = 4'h2;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        a_bus[3:0] = 4'h3;
        b_bus[3:0] = 4'h4;
        req = 4'b0001;
        step();
        n_checks++;
        if (busy !== 1'b1 || gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_setup: got busy=%b gnt=%b want 1 0001", busy, gnt);
        end
        req = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({gnt, busy, done, res_e, res_g, res_l, res_id, cmp_cnt} !== 19'd0) begin
            n_fail++;
            $display("FAIL abort_reset: got gnt=%b busy=%b done=%b egl=%b%b%b id=%0d cnt=%0d want all 0",
                     gnt, busy, done, res_e, res_g, res_l, res_id, cmp_cnt);
        end
        a_bus[7:4] = 4'h1;
        b_bus[7:4] = 4'h1;
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL abort_regrant: got gnt=%b want 0010", gnt);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (done !== 1'b1 || res_id !== 2'd1 || res_e !== 1'b1 || cmp_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL abort_after: got done=%b id=%0d e=%b cnt=%0d want 1 1 1 1",
                     done, res_id, res_e, cmp_cnt);
        end
    endtask

    task automatic test_operand_latch();
        do_reset();
        a_bus = 16'h0000;
        b_bus = 16'h0000;
        a_bus[3:0] = 4'hF;
        b_bus[3:0] = 4'h0;
        req = 4'b0001;
        step();
        a_bus[3:0] = 4'h0;
        b_bus[3:0] = 4'hF;
        req = 4'b0000;
        step();
        n_checks++;
        if (done !== 1'b1 || {res_e, res_g, res_l} !== 3'b010) begin
            n_fail++;
            $display("FAIL latch: got done=%b egl=%b%b%b want 1 010", done, res_e, res_g, res_l);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        logic [7:0] exp_cnt;
        dones = 0;
        do_reset();
        a_bus = 16'h0000;
        b_bus = 16'h0000;
        a_bus[3:0] = 4'h2;
        b_bus[3:0] = 4'h6;
        req = 4'b0001;
        for (int i = 1; i <= 256; i++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || gnt !== 4'b0001) begin
                n_fail++;
                $display("FAIL b2b_grant%0d: got done=%b gnt=%b want 0 0001", i, done, gnt);
            end
            if (i == 256) req = 4'b0000;
            step();
            if (done === 1'b1) dones++;
            exp_cnt = i[7:0];
            n_checks++;
            if (done !== 1'b1 || cmp_cnt !== exp_cnt || res_l !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_done%0d: got done=%b cnt=%0d l=%b want 1 %0d 1",
                         i, done, cmp_cnt, res_l, exp_cnt);
            end
        end
        step();
        n_checks++;
        if (dones != 256 || cmp_cnt !== 8'd0 || gnt !== 4'b0000 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_wrap: got dones=%0d cnt=%0d gnt=%b done=%b want 256 0 0000 0",
                     dones, cmp_cnt, gnt, done);
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        a_bus = 16'h0;
        b_bus = 16'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_reset_mid_op();
        test_operand_latch();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
